// File: rtl/compat_fadc_decim_40mhz_pkg.sv
// Shared constants for the 40 MHz compatibility-trigger front end:
// sample widths, binomial kernel, rounding and phase encoding.
package compat_fadc_decim_40mhz_pkg;

   localparam int DEF_ADC_WIDTH   = 12;
   localparam int DEF_SUM_WIDTH   = 16;
   localparam int DEF_FILL_CYCLES = 6;

   localparam int NUM_PMT      = 3;
   localparam int NUM_TAPS     = 5;
   localparam int KERNEL_SHIFT = 4;
   localparam int ROUND_CONST  = 8;
   localparam int KERNEL_COEF [NUM_TAPS] = '{1, 4, 6, 4, 1};

   typedef enum logic [1:0] {
      PHASE_0 = 2'd0,
      PHASE_1 = 2'd1,
      PHASE_2 = 2'd2
   } phase_e;

   function automatic phase_e next_phase(input phase_e cur);
      phase_e nxt;
      case (cur)
         PHASE_0: nxt = PHASE_1;
         PHASE_1: nxt = PHASE_2;
         default: nxt = PHASE_0;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/fir5_binomial.sv
// One PMT channel: 5-tap shift register, registered binomial sum and a
// rounded, decimated output register loaded on the shared update enable.
module fir5_binomial
   import compat_fadc_decim_40mhz_pkg::*;
#(
   parameter int ADC_WIDTH = DEF_ADC_WIDTH,
   parameter int SUM_WIDTH = DEF_SUM_WIDTH
) (
   input  logic                 CLK120,
   input  logic                 RESETN,
   input  logic [ADC_WIDTH-1:0] ADC,
   input  logic                 UPDATE,
   output logic [ADC_WIDTH-1:0] ADC40
);

   logic [ADC_WIDTH-1:0] tap_reg [NUM_TAPS];
   logic [SUM_WIDTH-1:0] term [NUM_TAPS];
   logic [SUM_WIDTH-1:0] sum_reg;
   logic [SUM_WIDTH-1:0] sum_next;
   logic [SUM_WIDTH-1:0] rounded;
   logic [ADC_WIDTH-1:0] adc40_reg;

   // 16*max sample still fits SUM_WIDTH, so the products need no extra headroom.
   for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_term
      assign term[gi] = SUM_WIDTH'(KERNEL_COEF[gi]) * SUM_WIDTH'(tap_reg[gi]);
   end

   always_comb begin
      sum_next = '0;
      for (int i = 0; i < NUM_TAPS; i++) begin
         sum_next = sum_next + term[i];
      end
   end

   assign rounded = sum_reg + SUM_WIDTH'(ROUND_CONST);

   always_ff @(posedge CLK120 or negedge RESETN) begin
      if (!RESETN) begin
         for (int i = 0; i < NUM_TAPS; i++) begin
            tap_reg[i] <= '0;
         end
         sum_reg   <= '0;
         adc40_reg <= '0;
      end else begin
         tap_reg[0] <= ADC;
         for (int i = 1; i < NUM_TAPS; i++) begin
            tap_reg[i] <= tap_reg[i-1];
         end
         sum_reg <= sum_next;
         if (UPDATE) begin
            adc40_reg <= ADC_WIDTH'(rounded >> KERNEL_SHIFT);
         end
      end
   end

   assign ADC40 = adc40_reg;

endmodule

// File: rtl/compat_fadc_decim_40mhz.sv
// 40 MHz front end: shared ENABLE40 phase counter, pipeline fill counter and
// three binomial decimating filters feeding the compatibility triggers.
module compat_fadc_decim_40mhz
   import compat_fadc_decim_40mhz_pkg::*;
#(
   parameter int ADC_WIDTH   = DEF_ADC_WIDTH,
   parameter int SUM_WIDTH   = DEF_SUM_WIDTH,
   parameter int FILL_CYCLES = DEF_FILL_CYCLES
) (
   input  logic                 CLK120,
   input  logic                 RESETN,
   input  logic                 SYNC,
   input  logic [ADC_WIDTH-1:0] ADC0,
   input  logic [ADC_WIDTH-1:0] ADC1,
   input  logic [ADC_WIDTH-1:0] ADC2,
   output logic [1:0]           ENABLE40,
   output logic [ADC_WIDTH-1:0] ADC40_0,
   output logic [ADC_WIDTH-1:0] ADC40_1,
   output logic [ADC_WIDTH-1:0] ADC40_2,
   output logic                 VALID40,
   output logic                 READY
);

   localparam int FILL_W = $clog2(FILL_CYCLES + 1);

   phase_e              enable40_reg;
   phase_e              enable40_next;
   logic [FILL_W-1:0]   fill_cnt_reg;
   logic                valid40_reg;
   logic                ready;
   logic                update_en;
   logic [ADC_WIDTH-1:0] adc_in [NUM_PMT];
   logic [ADC_WIDTH-1:0] adc40 [NUM_PMT];

   assign ready = (fill_cnt_reg == FILL_W'(FILL_CYCLES));
   // Decided from the registered phase, so a SYNC in the update cycle
   // cannot cancel the update already due.
   assign update_en = (enable40_reg == PHASE_0) && ready;

   always_comb begin
      enable40_next = next_phase(enable40_reg);
      if (SYNC) begin
         enable40_next = PHASE_0;
      end
   end

   always_ff @(posedge CLK120 or negedge RESETN) begin
      if (!RESETN) begin
         enable40_reg <= PHASE_0;
         fill_cnt_reg <= '0;
         valid40_reg  <= 1'b0;
      end else begin
         enable40_reg <= enable40_next;
         if (!ready) begin
            fill_cnt_reg <= fill_cnt_reg + FILL_W'(1);
         end
         valid40_reg <= update_en;
      end
   end

   assign adc_in[0] = ADC0;
   assign adc_in[1] = ADC1;
   assign adc_in[2] = ADC2;

   for (genvar gi = 0; gi < NUM_PMT; gi++) begin : g_pmt
      fir5_binomial #(
         .ADC_WIDTH (ADC_WIDTH),
         .SUM_WIDTH (SUM_WIDTH)
      ) u_fir (
         .CLK120 (CLK120),
         .RESETN (RESETN),
         .ADC    (adc_in[gi]),
         .UPDATE (update_en),
         .ADC40  (adc40[gi])
      );
   end

   assign ENABLE40 = enable40_reg;
   assign ADC40_0  = adc40[0];
   assign ADC40_1  = adc40[1];
   assign ADC40_2  = adc40[2];
   assign VALID40  = valid40_reg;
   assign READY    = ready;

endmodule

// File: tb/tb_compat_fadc_decim_40mhz.sv
// Directed bench for compat_fadc_decim_40mhz: reset, DC gain, impulse
// alignment, rounding, SYNC realignment and asynchronous mid-run reset.
module tb_compat_fadc_decim_40mhz;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        sync = 1'b0;
   logic [11:0] adc0 = '0;
   logic [11:0] adc1 = '0;
   logic [11:0] adc2 = '0;
   logic [1:0]  enable40;
   logic [11:0] adc40_0;
   logic [11:0] adc40_1;
   logic [11:0] adc40_2;
   logic        valid40;
   logic        ready;

   int n_cmp = 0;
   int n_bad = 0;
   int sync_en  [9];
   int sync_val [9];

   always #4 clk = ~clk;

   compat_fadc_decim_40mhz dut (
      .CLK120   (clk),
      .RESETN   (resetn),
      .SYNC     (sync),
      .ADC0     (adc0),
      .ADC1     (adc1),
      .ADC2     (adc2),
      .ENABLE40 (enable40),
      .ADC40_0  (adc40_0),
      .ADC40_1  (adc40_1),
      .ADC40_2  (adc40_2),
      .VALID40  (valid40),
      .READY    (ready)
   );

   // Release lands on a negedge, so the next posedge is edge 1.
   task automatic do_reset(input logic [11:0] a0, input logic [11:0] a1, input logic [11:0] a2);
      resetn = 1'b0;
      sync   = 1'b0;
      adc0   = a0;
      adc1   = a1;
      adc2   = a2;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic test_reset;
      resetn = 1'b0; sync = 1'b0;
      adc0 = 12'd4095; adc1 = 12'd4095; adc2 = 12'd4095;
      repeat (3) @(negedge clk);
      n_cmp++; if (enable40 !== 2'd0) begin n_bad++; $display("FAIL rst_enable40: got %0d want 0", enable40); end
      n_cmp++; if (adc40_0 !== 12'd0) begin n_bad++; $display("FAIL rst_adc40_0: got %0d want 0", adc40_0); end
      n_cmp++; if (adc40_1 !== 12'd0) begin n_bad++; $display("FAIL rst_adc40_1: got %0d want 0", adc40_1); end
      n_cmp++; if (adc40_2 !== 12'd0) begin n_bad++; $display("FAIL rst_adc40_2: got %0d want 0", adc40_2); end
      n_cmp++; if (valid40 !== 1'b0) begin n_bad++; $display("FAIL rst_valid40: got %0b want 0", valid40); end
      n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %0b want 0", ready); end
      resetn = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         n_cmp++; if (enable40 !== 2'(k % 3)) begin n_bad++; $display("FAIL fill_enable40 k=%0d: got %0d want %0d", k, enable40, k % 3); end
         n_cmp++; if (ready !== (k >= 6)) begin n_bad++; $display("FAIL fill_ready k=%0d: got %0b want %0b", k, ready, k >= 6); end
         n_cmp++; if (valid40 !== (k == 7)) begin n_bad++; $display("FAIL fill_valid40 k=%0d: got %0b want %0b", k, valid40, k == 7); end
         n_cmp++; if (adc40_0 !== ((k == 7) ? 12'd4095 : 12'd0)) begin n_bad++; $display("FAIL fill_adc40_0 k=%0d: got %0d", k, adc40_0); end
      end
   endtask

   task automatic test_dc_gain;
      int last_k;
      int n_valid;
      last_k = -1;
      n_valid = 0;
      do_reset(12'd1000, 12'd0, 12'd4095);
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (valid40 === 1'b1) begin
            $display("txn dc k=%0d adc40=%0d/%0d/%0d", k, adc40_0, adc40_1, adc40_2);
            n_cmp++; if (adc40_0 !== 12'd1000) begin n_bad++; $display("FAIL dc_adc40_0 k=%0d: got %0d want 1000", k, adc40_0); end
            n_cmp++; if (adc40_1 !== 12'd0) begin n_bad++; $display("FAIL dc_adc40_1 k=%0d: got %0d want 0", k, adc40_1); end
            n_cmp++; if (adc40_2 !== 12'd4095) begin n_bad++; $display("FAIL dc_adc40_2 k=%0d: got %0d want 4095", k, adc40_2); end
            if (last_k < 0) begin
               n_cmp++; if (k != 7) begin n_bad++; $display("FAIL dc_first_valid: got edge %0d want 7", k); end
            end else begin
               n_cmp++; if (k - last_k != 3) begin n_bad++; $display("FAIL dc_spacing k=%0d: got %0d want 3", k, k - last_k); end
            end
            last_k = k;
            n_valid++;
         end
      end
      n_cmp++; if (n_valid != 8) begin n_bad++; $display("FAIL dc_valid_count: got %0d want 8", n_valid); end
   endtask

   // Sample of amplitude amp is driven for the edge after k_imp; updates land
   // on edges 10, 13, 16, 19 after reset release.
   task automatic test_impulse(input string name, input int k_imp, input logic [11:0] amp,
                               input int exp13, input int exp16, input int exp19);
      do_reset(12'd0, 12'd0, 12'd0);
      for (int k = 1; k <= 19; k++) begin
         @(negedge clk);
         if (k == 10 || k == 13 || k == 16 || k == 19) begin
            int want;
            want = (k == 13) ? exp13 : (k == 16) ? exp16 : (k == 19) ? exp19 : 0;
            $display("txn %s k=%0d adc40_0=%0d valid=%0b", name, k, adc40_0, valid40);
            n_cmp++; if (valid40 !== 1'b1) begin n_bad++; $display("FAIL %s_valid k=%0d: got %0b want 1", name, k, valid40); end
            n_cmp++; if (adc40_0 !== 12'(want)) begin n_bad++; $display("FAIL %s_adc40_0 k=%0d: got %0d want %0d", name, k, adc40_0, want); end
            if (k == 13) begin
               n_cmp++; if (adc40_1 !== 12'd0) begin n_bad++; $display("FAIL %s_adc40_1: got %0d want 0", name, adc40_1); end
            end
         end
         adc0 = (k == k_imp) ? amp : 12'd0;
      end
   endtask

   task automatic test_sync(input string name, input int k_sync);
      do_reset(12'd160, 12'd0, 12'd0);
      for (int k = 1; k <= k_sync + 8; k++) begin
         @(negedge clk);
         if (k >= k_sync) begin
            int i;
            i = k - k_sync;
            n_cmp++; if (enable40 !== 2'(sync_en[i])) begin n_bad++; $display("FAIL %s_enable40 k=%0d: got %0d want %0d", name, k, enable40, sync_en[i]); end
            n_cmp++; if (valid40 !== 1'(sync_val[i])) begin n_bad++; $display("FAIL %s_valid40 k=%0d: got %0b want %0d", name, k, valid40, sync_val[i]); end
            if (sync_val[i] == 1) begin
               $display("txn %s k=%0d adc40_0=%0d", name, k, adc40_0);
               n_cmp++; if (adc40_0 !== 12'd160) begin n_bad++; $display("FAIL %s_adc40_0 k=%0d: got %0d want 160", name, k, adc40_0); end
            end
         end
         sync = (k == k_sync);
      end
      sync = 1'b0;
   endtask

   task automatic test_sync_hold;
      do_reset(12'd160, 12'd0, 12'd0);
      for (int k = 1; k <= 13; k++) begin
         @(negedge clk);
         if (k >= 9) begin
            int want_en;
            want_en = (k <= 11) ? 0 : k - 11;
            n_cmp++; if (enable40 !== 2'(want_en)) begin n_bad++; $display("FAIL hold_enable40 k=%0d: got %0d want %0d", k, enable40, want_en); end
            n_cmp++; if (valid40 !== (k >= 10 && k <= 12)) begin n_bad++; $display("FAIL hold_valid40 k=%0d: got %0b", k, valid40); end
         end
         sync = (k >= 8 && k <= 10);
      end
      sync = 1'b0;
   endtask

   task automatic test_midrun_reset;
      do_reset(12'd1000, 12'd0, 12'd0);
      repeat (10) @(negedge clk);
      n_cmp++; if (valid40 !== 1'b1 || adc40_0 !== 12'd1000) begin n_bad++; $display("FAIL mid_pre: got valid=%0b adc=%0d want 1/1000", valid40, adc40_0); end
      #2 resetn = 1'b0;
      #1;
      n_cmp++; if (enable40 !== 2'd0) begin n_bad++; $display("FAIL mid_enable40: got %0d want 0", enable40); end
      n_cmp++; if (adc40_0 !== 12'd0) begin n_bad++; $display("FAIL mid_adc40_0: got %0d want 0", adc40_0); end
      n_cmp++; if (valid40 !== 1'b0) begin n_bad++; $display("FAIL mid_valid40: got %0b want 0", valid40); end
      n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL mid_ready: got %0b want 0", ready); end
      @(negedge clk);
      resetn = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         n_cmp++; if (valid40 !== (k == 7)) begin n_bad++; $display("FAIL mid_refill_valid k=%0d: got %0b", k, valid40); end
         n_cmp++; if (ready !== (k >= 6)) begin n_bad++; $display("FAIL mid_refill_ready k=%0d: got %0b", k, ready); end
      end
   endtask

   initial begin
      test_reset();
      test_dc_gain();
      test_impulse("impulse_centre", 8, 12'd1600, 600, 0, 0);
      test_impulse("impulse_early", 9, 12'd1600, 400, 100, 0);
      test_impulse("impulse_late", 10, 12'd1600, 100, 400, 0);
      test_impulse("round_one", 8, 12'd1, 0, 0, 0);
      test_impulse("round_three", 8, 12'd3, 1, 0, 0);
      sync_en  = '{1, 0, 1, 2, 0, 1, 2, 0, 1};
      sync_val = '{1, 0, 1, 0, 0, 1, 0, 0, 1};
      test_sync("sync_ph1", 10);
      sync_en  = '{0, 0, 1, 2, 0, 1, 2, 0, 1};
      sync_val = '{0, 1, 1, 0, 0, 1, 0, 0, 1};
      test_sync("sync_ph0", 9);
      test_sync_hold();
      test_midrun_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
